// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//
// Multi-cycle WIDTH-bit adder/subtractor. After a start is accepted the
// operation runs for N = WIDTH/CHUNK cycles. Each cycle adds one CHUNK-bit
// slice of the operands and passes the carry to the next slice through a
// register. The result, carry-out and signed overflow are published
// together when the last chunk completes.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      operation request, sampled only while idle
//   a      in   WIDTH  operand A, sampled with start
//   b      in   WIDTH  operand B, sampled with start
//   cin    in   1      carry-in for add mode (ignored when sub=1)
//   sub    in   1      0: a+b+cin, 1: a-b
//   busy   out  1      high while chunks are being processed
//   done   out  1      one-cycle pulse when sum/cout/ovf are loaded
//   sum    out  WIDTH  result, held between operations
//   cout   out  1      carry out of the MSB (sub: 1 means no borrow)
//   ovf    out  1      two's-complement overflow of the operation
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    logic [0:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q,   opa_d;
    logic [WIDTH-1:0] opb_q,   opb_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;
    logic             done_q,  done_d;

    logic [CHUNK-1:0] chunk_a_s;
    logic [CHUNK-1:0] chunk_b_s;
    logic [CHUNK:0]   chunk_sum_s;

    // Slice adder for the chunk currently selected by idx.
    always_comb begin
        chunk_a_s   = opa_q[idx_q*CHUNK +: CHUNK];
        chunk_b_s   = opb_q[idx_q*CHUNK +: CHUNK];
        chunk_sum_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state logic for the IDLE/RUN sequencer and the datapath registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = {IDXW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d[idx_q*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
                carry_d = chunk_sum_s[CHUNK];
                if (idx_q == IDX_LAST) begin
                    // work_d already holds the final chunk, so the whole
                    // result is published in the same edge.
                    sum_d   = work_d;
                    cout_d  = chunk_sum_s[CHUNK];
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (work_d[WIDTH-1] != opa_q[WIDTH-1]);
                    done_d  = 1'b1;
                    idx_d   = {IDXW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IDXW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDXW{1'b0}};
            carry_q <= 1'b0;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            work_q  <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
//
// Directed and randomized checks of seq_chunk_adder in three configurations:
// 16/4 (main), 8/8 (single chunk) and 8/1 (bit-serial). Expected values come
// from an arithmetic reference model of the add/subtract/overflow rules.
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 16-bit, 4-bit chunk instance
    logic        start;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    // 8-bit instances share one set of inputs
    logic        start8;
    logic [7:0]  a8, b8;
    logic        cin8, sub8;
    logic        busy_w, done_w, cout_w, ovf_w;
    logic [7:0]  sum_w;
    logic        busy_n, done_n, cout_n, ovf_n;
    logic [7:0]  sum_n;

    int checks = 0;
    int errors = 0;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_w (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy_w), .done(done_w), .sum(sum_w), .cout(cout_w), .ovf(ovf_w)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_n (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy_n), .done(done_n), .sum(sum_n), .cout(cout_n), .ovf(ovf_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                         input logic sb, input int w,
                         output logic [31:0] s, output logic co, output logic ov);
        longint m, ua, ub, sa, sbv, t, st;
        m   = longint'(1) << w;
        ua  = longint'(av);
        ub  = longint'(bv);
        sa  = av[w-1] ? ua - m : ua;
        sbv = bv[w-1] ? ub - m : ub;
        if (!sb) begin
            t  = ua + ub + longint'(ci);
            st = sa + sbv + longint'(ci);
            co = (t >= m);
            s  = 32'(t % m);
        end else begin
            st = sa - sbv;
            co = (ua >= ub);
            s  = 32'((ua - ub + m) % m);
        end
        ov = (st >= m / 2) || (st < -(m / 2));
    endtask

    // One operation on the 16/4 instance; entered and left #1 after an edge.
    task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input string tag);
        logic [31:0] es;
        logic        eco, eov, mid_ok;
        logic [15:0] prev;
        int          lat;
        model(32'(av), 32'(bv), ci, sb, 16, es, eco, eov);
        prev = sum;
        a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        mid_ok = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1 || lat > 20) break;
            if (busy !== 1'b1 || sum !== prev) mid_ok = 1'b0;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_no_partial"}, 32'(mid_ok), 32'd1);
        chk({tag, "_sum"}, 32'(sum), es);
        chk({tag, "_cout"}, 32'(cout), 32'(eco));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // One operation on both 8-bit instances; checks each at its own done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input string tag);
        logic [31:0] es;
        logic        eco, eov;
        int          lat_w, lat_n;
        model(32'(av), 32'(bv), ci, sb, 8, es, eco, eov);
        a8 = av; b8 = bv; cin8 = ci; sub8 = sb; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat_w = -1;
        lat_n = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done_w === 1'b1 && lat_w < 0) begin
                lat_w = k;
                chk({tag, "_w_sum"}, 32'(sum_w), es);
                chk({tag, "_w_cout"}, 32'(cout_w), 32'(eco));
                chk({tag, "_w_ovf"}, 32'(ovf_w), 32'(eov));
            end
            if (done_n === 1'b1 && lat_n < 0) begin
                lat_n = k;
                chk({tag, "_n_sum"}, 32'(sum_n), es);
                chk({tag, "_n_cout"}, 32'(cout_n), 32'(eco));
                chk({tag, "_n_ovf"}, 32'(ovf_n), 32'(eov));
            end
        end
        chk({tag, "_w_latency"}, 32'(lat_w), 32'd1);
        chk({tag, "_n_latency"}, 32'(lat_n), 32'd8);
    endtask

    initial begin : stimulus
        logic [31:0] es1, es2;
        logic        eco1, eov1, eco2, eov2;
        logic        saw_done;

        rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
        start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; sub8 = 1'b0;

        // Reset acts with no clock edge
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run16(16'h00FF, 16'h0001, 1'b0, 1'b0, "add_carry_chain");
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
        run16(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
        run16(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        run16(16'h1234, 16'h0000, 1'b1, 1'b0, "add_cin");

        // start during busy is ignored and not queued
        model(32'h1111, 32'h2222, 1'b0, 1'b0, 16, es1, eco1, eov1);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        @(posedge clk); #1;                       // E0+1
        a = 16'hFFFF; b = 16'h0F0F; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;                       // E0+2 start ignored
        start = 1'b0;
        @(posedge clk); #1;                       // E0+3
        @(posedge clk); #1;                       // E0+4
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_sum", 32'(sum), es1);
        @(posedge clk); #1;
        chk("ign_not_queued", 32'(busy), 32'd0);

        // start held high: second op accepted in the done cycle
        model(32'h0F0F, 32'h00F1, 1'b1, 1'b0, 16, es1, eco1, eov1);
        model(32'h4000, 32'hC001, 1'b0, 1'b1, 16, es2, eco2, eov2);
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E0
        a = 16'h4000; b = 16'hC001; cin = 1'b0; sub = 1'b1;
        repeat (4) begin @(posedge clk); #1; end  // E0+4
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_busy1", 32'(busy), 32'd0);
        chk("b2b_sum1", 32'(sum), es1);
        chk("b2b_cout1", 32'(cout), 32'(eco1));
        @(posedge clk); #1;                       // E0+5 second accept
        start = 1'b0;
        chk("b2b_accept", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        repeat (4) begin @(posedge clk); #1; end  // E0+9
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_sum2", 32'(sum), es2);
        chk("b2b_cout2", 32'(cout), 32'(eco2));
        chk("b2b_ovf2", 32'(ovf), 32'(eov2));
        @(posedge clk); #1;

        // Reset mid-RUN aborts with no done
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        @(posedge clk); #1;                       // E0+1
        @(posedge clk); #1;                       // E0+2
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        run16(16'h1234, 16'h1111, 1'b0, 1'b0, "after_abort");

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand16");
        end

        // Chunk extremes
        run8(8'h80, 8'h80, 1'b0, 1'b0, "chunk_ext");
        run8(8'h7F, 8'hFF, 1'b1, 1'b1, "chunk_sub");
        for (int i = 0; i < 8; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand8");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
